// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default requester count.
package uart_tx_arbiter_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational wrap-around priority search: first set request at or after the pointer.
module uart_rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [PW-1:0] idx_o,
    output logic          found_o
);

    int            cand;
    logic [PW-1:0] cand_idx;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found_o  = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            // Explicit wrap keeps non-power-of-two N from indexing past N-1.
            cand = int'(ptr_i) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            cand_idx = PW'(cand);
            if (!found_o && req_i[cand_idx]) begin
                found_o            = 1'b1;
                onehot_o[cand_idx] = 1'b1;
                idx_o              = cand_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N byte requesters.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           iCLOCK,
    input  logic           iRESET,
    input  logic           iRESET_SYNC,
    input  logic [N-1:0]   iREQ_VALID,
    input  logic [8*N-1:0] iREQ_DATA,
    output logic [N-1:0]   oREQ_ACK,
    output logic [N-1:0]   oGRANT,
    output logic           oTX_VALID,
    output logic [7:0]     oTX_DATA,
    input  logic           iTX_BUSY,
    output logic           oACTIVE
);

    localparam int PW = $clog2(N);

    state_t        state_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] idx_q;
    logic [7:0]    data_q;
    logic [N-1:0]  grant_q;
    logic [N-1:0]  ack_q;
    logic          tx_valid_q;

    logic [N-1:0]  pick_onehot;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic [7:0]    pick_data;
    logic [PW-1:0] ptr_d;

    uart_rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req_i    (iREQ_VALID),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .found_o  (pick_found)
    );

    always_comb begin
        pick_data = 8'h00;
        for (int i = 0; i < N; i++) begin
            if (pick_onehot[i]) begin
                pick_data = iREQ_DATA[8*i +: 8];
            end
        end
    end

    always_comb begin
        ptr_d = (idx_q == PW'(N - 1)) ? '0 : idx_q + 1'b1;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            data_q     <= 8'h00;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_valid_q <= 1'b0;
        end else if (iRESET_SYNC) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            idx_q      <= '0;
            data_q     <= 8'h00;
            grant_q    <= '0;
            ack_q      <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            ack_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_found) begin
                        data_q     <= pick_data;
                        idx_q      <= pick_idx;
                        grant_q    <= pick_onehot;
                        ack_q      <= pick_onehot;
                        tx_valid_q <= 1'b1;
                        state_q    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Requests are ignored here; BUSY stalls indefinitely.
                    if (!iTX_BUSY) begin
                        ptr_q      <= ptr_d;
                        grant_q    <= '0;
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign oREQ_ACK  = ack_q;
    assign oGRANT    = grant_q;
    assign oTX_VALID = tx_valid_q;
    assign oTX_DATA  = data_q;
    assign oACTIVE   = (state_q == ST_ISSUE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with N=4.
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst;
    logic        rst_sync;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ack;
    logic [3:0]  grant;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        active;

    int checks;
    int failures;

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] data;
        logic        busy;
        logic        sync;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic        txv;
        logic [7:0]  txd;
        logic        act;
    } vec_t;

    vec_t vecs[17];

    uart_tx_arbiter #(.N(4)) dut (
        .iCLOCK      (clk),
        .iRESET      (rst),
        .iRESET_SYNC (rst_sync),
        .iREQ_VALID  (req_valid),
        .iREQ_DATA   (req_data),
        .oREQ_ACK    (req_ack),
        .oGRANT      (grant),
        .oTX_VALID   (tx_valid),
        .oTX_DATA    (tx_data),
        .iTX_BUSY    (tx_busy),
        .oACTIVE     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] v, input logic [31:0] d, input logic b,
                                input logic s, input logic [3:0] a, input logic [3:0] g,
                                input logic tv, input logic [7:0] td, input logic ac);
        vec_t r;
        r.valid = v; r.data = d; r.busy = b; r.sync = s;
        r.ack = a; r.grant = g; r.txv = tv; r.txd = td; r.act = ac;
        return r;
    endfunction

    task automatic drive(input logic [3:0] v, input logic [31:0] d, input logic b, input logic s);
        req_valid = v;
        req_data  = d;
        tx_busy   = b;
        rst_sync  = s;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] a, input logic [3:0] g,
                              input logic tv, input logic [7:0] td, input logic ac);
        check({tag, ".ack"},    32'(req_ack),  32'(a));
        check({tag, ".grant"},  32'(grant),    32'(g));
        check({tag, ".txv"},    32'(tx_valid), 32'(tv));
        check({tag, ".txd"},    32'(tx_data),  32'(td));
        check({tag, ".active"}, 32'(active),   32'(ac));
    endtask

    initial begin
        int ack_cnt;
        int txv_cnt;
        checks   = 0;
        failures = 0;

        // Single requester, wrap-around, sync-reset priority, then full rotation.
        vecs[0]  = mk(4'b0100, 32'h00A50000, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'hA5, 1'b1);
        vecs[1]  = mk(4'b0000, 32'h00A50000, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hA5, 1'b0);
        vecs[2]  = mk(4'b0011, 32'h00003130, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h30, 1'b1);
        vecs[3]  = mk(4'b0010, 32'h00003130, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h30, 1'b0);
        vecs[4]  = mk(4'b0010, 32'h00003130, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h31, 1'b1);
        vecs[5]  = mk(4'b0000, 32'h00003130, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h31, 1'b0);
        vecs[6]  = mk(4'b1111, 32'h13121110, 1'b0, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        vecs[7]  = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        vecs[8]  = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h10, 1'b0);
        vecs[9]  = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b1, 8'h11, 1'b1);
        vecs[10] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h11, 1'b0);
        vecs[11] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0100, 4'b0100, 1'b1, 8'h12, 1'b1);
        vecs[12] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h12, 1'b0);
        vecs[13] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b1, 8'h13, 1'b1);
        vecs[14] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h13, 1'b0);
        vecs[15] = mk(4'b1111, 32'h13121110, 1'b0, 1'b0, 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        vecs[16] = mk(4'b0000, 32'h13121110, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h10, 1'b0);

        rst = 1'b1;
        drive(4'b0000, 32'h0, 1'b0, 1'b0);
        step();
        step();
        check_outs("reset", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        step();
        check_outs("post_reset_idle", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);

        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].busy, vecs[i].sync);
            step();
            check_outs($sformatf("vec%0d", i), vecs[i].ack, vecs[i].grant,
                       vecs[i].txv, vecs[i].txd, vecs[i].act);
            $display("vec%0d valid=%b busy=%b sync=%b -> ack=%b grant=%b txv=%b txd=%h act=%b",
                     i, vecs[i].valid, vecs[i].busy, vecs[i].sync, req_ack, grant, tx_valid, tx_data, active);
        end

        // Backpressure: ptr=1, requester 2 granted, BUSY held for 5 cycles.
        ack_cnt = 0;
        txv_cnt = 0;
        drive(4'b0100, 32'h005C0000, 1'b1, 1'b0);
        step();
        check_outs("bp_grant", 4'b0100, 4'b0100, 1'b1, 8'h5C, 1'b1);
        if (req_ack != 4'b0000) ack_cnt++;
        if (tx_valid) txv_cnt++;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001, 32'hEEEEEEEE, 1'b1, 1'b0);
            step();
            check_outs($sformatf("bp_hold%0d", i), 4'b0000, 4'b0100, 1'b1, 8'h5C, 1'b1);
            if (req_ack != 4'b0000) ack_cnt++;
            if (tx_valid) txv_cnt++;
        end
        drive(4'b0000, 32'h0, 1'b0, 1'b0);
        step();
        check_outs("bp_done", 4'b0000, 4'b0000, 1'b0, 8'h5C, 1'b0);
        check("bp_ack_count", 32'(ack_cnt), 32'd1);
        check("bp_txv_cycles", 32'(txv_cnt), 32'd6);
        $display("backpressure acks=%0d txv_cycles=%0d", ack_cnt, txv_cnt);

        // Sync reset during ISSUE: ptr=3, so requester 2 is found after wrap.
        drive(4'b0100, 32'h00770000, 1'b1, 1'b0);
        step();
        check_outs("srst_grant", 4'b0100, 4'b0100, 1'b1, 8'h77, 1'b1);
        drive(4'b0000, 32'h0, 1'b1, 1'b1);
        step();
        check_outs("srst_clear", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        drive(4'b1111, 32'h13121110, 1'b0, 1'b0);
        step();
        check_outs("srst_restart", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        drive(4'b0000, 32'h0, 1'b0, 1'b0);
        step();
        check_outs("srst_done", 4'b0000, 4'b0000, 1'b0, 8'h10, 1'b0);
        $display("sync reset restart grant sequence checked");

        // Asynchronous reset mid-cycle during ISSUE: ptr=1, requester 2 granted.
        drive(4'b0100, 32'h00880000, 1'b1, 1'b0);
        step();
        check_outs("arst_grant", 4'b0100, 4'b0100, 1'b1, 8'h88, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("arst_immediate", 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0);
        #1;
        rst = 1'b0;
        drive(4'b1111, 32'h13121110, 1'b0, 1'b0);
        step();
        check_outs("arst_restart", 4'b0001, 4'b0001, 1'b1, 8'h10, 1'b1);
        $display("async reset mid-cycle checked");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
